// File: rtl/ex_cc_stage_pkg.sv
// Y86-64 execute back-end shared constants.
// icodes, condition selectors, flag indices, CC reset value.
package ex_cc_stage_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] ICODE_OPQ  = IOPQ;
  localparam logic [3:0] ICODE_CMOV = IRRMOVQ;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  localparam int CF_ZF = 0;
  localparam int CF_SF = 1;
  localparam int CF_OF = 2;

  localparam logic [2:0] CC_RESET = 3'b001;

endpackage

// File: rtl/ex_cc_stage_cond_eval.sv
// Branch/cmov condition evaluator: (ifun, cc{OF,SF,ZF}) -> cnd.
// Purely combinational; shared with the fetch-side predictor checker.
module ex_cc_stage_cond_eval
  import ex_cc_stage_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cnd
);

  logic z, s, o, lt;

  assign z  = cc[CF_ZF];
  assign s  = cc[CF_SF];
  assign o  = cc[CF_OF];
  assign lt = s ^ o;

  always_comb begin
    cnd = 1'b0;
    unique case (1'b1)
      (ifun == C_YES): cnd = 1'b1;
      (ifun == C_LE):  cnd = lt | z;
      (ifun == C_L):   cnd = lt;
      (ifun == C_E):   cnd = z;
      (ifun == C_NE):  cnd = !z;
      (ifun == C_GE):  cnd = !lt;
      (ifun == C_G):   cnd = !lt & !z;
      default:         cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_cc_stage.sv
// Execute back end: CC register, Cnd evaluation, E->M register.
// Ports: e_* beat in (valid/ready), m_* beat out, m_exc, flush, cc.
module ex_cc_stage
  import ex_cc_stage_pkg::*;
#(
  parameter int         W          = 64,
  parameter logic [3:0] ICODE_OPQ  = 4'h6,
  parameter logic [3:0] ICODE_CMOV = 4'h2,
  parameter logic [3:0] RNONE      = 4'hF,
  parameter logic [2:0] CC_RESET   = 3'b001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         e_valid,
  output logic         e_ready,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] e_valE,
  input  logic [2:0]   e_cf,
  input  logic [W-1:0] e_valA,
  input  logic [3:0]   e_dstE,
  input  logic         m_exc,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [3:0]   m_icode,
  output logic         m_Cnd,
  output logic [W-1:0] m_valE,
  output logic [W-1:0] m_valA,
  output logic [3:0]   m_dstE,
  output logic [2:0]   cc
);

  logic [2:0]   cc_q, cc_d;
  logic         vld_q, vld_d;
  logic [3:0]   icode_q, icode_d;
  logic         cnd_q, cnd_d;
  logic [W-1:0] vale_q, vale_d;
  logic [W-1:0] vala_q, vala_d;
  logic [3:0]   dste_q, dste_d;

  logic cnd;
  logic in_fire;
  logic out_fire;

  // Cnd sees the CC before this edge's update.
  ex_cc_stage_cond_eval u_cond (
    .ifun (e_ifun),
    .cc   (cc_q),
    .cnd  (cnd)
  );

  assign e_ready  = !vld_q | m_ready;
  assign in_fire  = e_valid & e_ready & !flush;
  assign out_fire = vld_q & m_ready;

  always_comb begin
    cc_d    = cc_q;
    vld_d   = vld_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    if (in_fire) begin
      vld_d   = 1'b1;
      icode_d = e_icode;
      cnd_d   = cnd;
      vale_d  = e_valE;
      vala_d  = e_valA;
      // Untaken cmov must not write back.
      dste_d  = (e_icode == ICODE_CMOV && !cnd)
              ? RNONE : e_dstE;
      if (e_icode == ICODE_OPQ && !m_exc)
        cc_d = e_cf;
    end else if (out_fire || flush) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q    <= CC_RESET;
      vld_q   <= 1'b0;
      icode_q <= 4'h0;
      cnd_q   <= 1'b0;
      vale_q  <= '0;
      vala_q  <= '0;
      dste_q  <= RNONE;
    end else begin
      cc_q    <= cc_d;
      vld_q   <= vld_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
    end
  end

  assign cc      = cc_q;
  assign m_valid = vld_q;
  assign m_icode = icode_q;
  assign m_Cnd   = cnd_q;
  assign m_valE  = vale_q;
  assign m_valA  = vala_q;
  assign m_dstE  = dste_q;

endmodule
